// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one pipelined FP adder among NUM_REQ lanes
// Build macro FP_ADD_ARB_FIXED_PRIO_EN selects fixed priority (lowest lane wins) instead of round-robin.
module fp_add_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ADD_LATENCY    = 2,
  localparam int W             = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
  localparam int IDXW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*W-1:0]      req_a,
  input  logic [NUM_REQ*W-1:0]      req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [W-1:0]              resp_data,
  output logic [W-1:0]              add_a,
  output logic [W-1:0]              add_b,
  input  logic                      add_sign,
  input  logic [EXPONENT_WIDTH-1:0] add_exp,
  input  logic [MANTISSA_WIDTH-1:0] add_mant,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state;
  logic [ADD_LATENCY-1:0] tag_vld;
  logic [IDXW-1:0]        tag_idx [ADD_LATENCY];
  logic                   found;
  logic                   accept;
  logic [IDXW-1:0]        grant_idx;
  logic [IDXW-1:0]        cidx;
  logic [W-1:0]           sel_a;
  logic [W-1:0]           sel_b;
  int                     cand;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
`else
  logic [IDXW-1:0]        ptr;
`endif

  // Candidate order: lane 0 upward, or rotating from the lane after the last grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(ptr) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      cidx = IDXW'(cand);
      if (!found && req_valid[cidx]) begin
        found     = 1'b1;
        grant_idx = cidx;
      end
    end
  end

  assign accept = found && (state == RUN) && !flush && !reset;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDXW'(k) == grant_idx) begin
        sel_a = req_a[k*W +: W];
        sel_b = req_b[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      add_a      <= '0;
      add_b      <= '0;
      tag_vld    <= '0;
      resp_valid <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) tag_idx[i] <= '0;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
`else
      ptr        <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      if (accept) begin
        add_a <= sel_a;
        add_b <= sel_b;
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
`else
        ptr   <= grant_idx;
`endif
      end
      // Tag pipe mirrors the adder depth; bubbles shift in on idle cycles.
      tag_vld[0] <= accept;
      tag_idx[0] <= grant_idx;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      resp_valid <= '0;
      if (tag_vld[ADD_LATENCY-1]) resp_valid[tag_idx[ADD_LATENCY-1]] <= 1'b1;
    end
  end

  // The adder result lands in the same cycle as the registered valid pulse.
  assign resp_data = (|resp_valid) ? {add_sign, add_exp, add_mant} : '0;
  assign busy      = |tag_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (!busy && !(|resp_valid)) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign flush_done = (state == DONE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - randomized bench for fp_add_arbiter against a cycle-scheduled model
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam int S_RUN = 0, S_DRAIN = 1, S_DONE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_data, add_a, add_b;
  logic          add_sign;
  logic [7:0]    add_exp;
  logic [22:0]   add_mant;
  logic          flush, flush_done, busy;

  fp_add_arbiter #(.NUM_REQ(N), .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ADD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_data(resp_data),
    .add_a(add_a), .add_b(add_b), .add_sign(add_sign), .add_exp(add_exp),
    .add_mant(add_mant), .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  // Stand-in for the external adder: L-stage pipeline from add_a/add_b.
  logic [31:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= fpadd(add_a, add_b);
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign {add_sign, add_exp, add_mant} = apipe[L-1];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic        pv [N];
  logic [31:0] pa [N], pb [N];
  logic        fl, rs;

  int          m_state, m_ptr, m_last;
  logic [31:0] m_add_a, m_add_b;
  int          sched_lane [int];
  logic [31:0] sched_sum [int];

  logic [N-1:0] last_ready;
  logic [31:0]  got [N];
  int           acc_cyc [N], resp_cyc [N];
  int           n_resp01, n_resp_all, n_fd, n_g3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_state = S_RUN; m_ptr = N - 1; m_last = -100;
    m_add_a = 32'd0; m_add_b = 32'd0;
    sched_lane.delete(); sched_sum.delete();
  endtask

  task automatic step();
    logic [N-1:0] er, ev;
    logic [31:0]  ed;
    int g, c;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_a[i*32 +: 32] = pa[i];
      req_b[i*32 +: 32] = pb[i];
    end
    flush = fl; reset = rs;
    #1;
    g = -1;
    if (!rs && m_state == S_RUN && !fl) begin
      for (int k = 0; k < N; k++) begin
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
        c = k;
`else
        c = (m_ptr + 1 + k) % N;
`endif
        if (g < 0 && pv[c]) g = c;
      end
    end
    er = (g >= 0) ? (N'(1) << g) : '0;
    ev = '0; ed = 32'd0;
    if (sched_lane.exists(cyc)) begin
      ev = N'(1) << sched_lane[cyc];
      ed = sched_sum[cyc];
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("resp_valid", 64'(resp_valid), 64'(ev));
    chk("resp_data", 64'(resp_data), 64'(ed));
    chk("add_a", 64'(add_a), 64'(m_add_a));
    chk("add_b", 64'(add_b), 64'(m_add_b));
    chk("busy", 64'(busy), 64'(m_last > cyc));
    chk("flush_done", 64'(flush_done), 64'(m_state == S_DONE));
    // raw DUT observations for the directed literal checks
    last_ready = req_ready;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) acc_cyc[i] = cyc;
      if (resp_valid[i]) begin got[i] = resp_data; resp_cyc[i] = cyc; end
    end
    n_resp01   += int'(resp_valid[0]) + int'(resp_valid[1]);
    n_resp_all += $countones(resp_valid);
    n_fd       += int'(flush_done);
    n_g3       += int'(req_ready[3] && req_valid[3]);
    if (sched_lane.exists(cyc)) begin sched_lane.delete(cyc); sched_sum.delete(cyc); end
    if (rs) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_add_a = pa[g]; m_add_b = pb[g];
        sched_lane[cyc+L+1] = g;
        sched_sum[cyc+L+1]  = fpadd(pa[g], pb[g]);
        m_last = cyc + L + 1;
        m_ptr = g;
        pv[g] = 1'b0;
      end
      case (m_state)
        S_RUN:   if (fl) m_state = S_DRAIN;
        S_DRAIN: if (m_last < cyc) m_state = S_DONE;
        default: m_state = S_RUN;
      endcase
    end
    cyc++;
  endtask

  task automatic clear_obs();
    n_resp01 = 0; n_resp_all = 0; n_fd = 0; n_g3 = 0;
    for (int i = 0; i < N; i++) begin got[i] = 32'hDEADBEEF; acc_cyc[i] = -1; resp_cyc[i] = -1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rs = 1'b1; step(); rs = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    fl = 1'b0; rs = 1'b0;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pa[i] = 32'd0; pb[i] = 32'd0; end
    clear_obs();
    model_reset();
    repeat (2) @(posedge clk);

    chk("pin_7.25+0.375", 64'(fpadd(32'h40E80000, 32'h3EC00000)), 64'h40F40000);
    chk("pin_4-4", 64'(fpadd(32'h40800000, 32'hC0800000)), 64'h00000000);
    chk("pin_-36+10", 64'(fpadd(32'hC2100000, 32'h41200000)), 64'hC1D00000);

    do_reset();
    chk("reset_outputs", 64'({resp_valid, req_ready, flush_done, busy}), 64'd0);

    // single op on lane 0
    clear_obs();
    pv[0] = 1'b1; pa[0] = 32'h40E80000; pb[0] = 32'h3EC00000;
    idle(6);
    chk("t1_data", 64'(got[0]), 64'h40F40000);
    chk("t1_latency", 64'(resp_cyc[0] - acc_cyc[0]), 64'd3);

    // all lanes continuously valid
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) begin pv[i] = 1'b1; pa[i] = rand_fp(); pb[i] = rand_fp(); end
      step();
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
      if (k < 5) chk("t2_grant_seq", 64'(last_ready), 64'(N'(1) << (k % N)));
`endif
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    idle(5);

    // exact cancellation and a negative sum, on two lanes at once
    clear_obs();
    pv[2] = 1'b1; pa[2] = 32'h40800000; pb[2] = 32'hC0800000;
    pv[1] = 1'b1; pa[1] = 32'hC2100000; pb[1] = 32'h41200000;
    idle(7);
    chk("t3_lane2", 64'(got[2]), 64'h00000000);
    chk("t3_lane1", 64'(got[1]), 64'hC1D00000);
    chk("t3_slots", 64'(resp_cyc[1] != resp_cyc[2]), 64'd1);

    // flush with two ops in flight and a waiting request
    clear_obs();
    pv[0] = 1'b1; pa[0] = rand_fp(); pb[0] = rand_fp();
    pv[1] = 1'b1; pa[1] = rand_fp(); pb[1] = rand_fp();
    idle(2);
    pv[3] = 1'b1; pa[3] = rand_fp(); pb[3] = rand_fp();
    fl = 1'b1; step(); fl = 1'b0;
    chk("t4_ready_off", 64'(last_ready), 64'd0);
    idle(7);
    chk("t4_resps", 64'(n_resp01), 64'd2);
    chk("t4_flush_done", 64'(n_fd), 64'd1);
    idle(6);

    // reset with two ops in flight
    pv[0] = 1'b1; pa[0] = rand_fp(); pb[0] = rand_fp();
    pv[1] = 1'b1; pa[1] = rand_fp(); pb[1] = rand_fp();
    idle(2);
    do_reset();
    clear_obs();
    idle(5);
    chk("t5_no_resp", 64'(n_resp_all), 64'd0);
    for (int i = 0; i < N; i++) begin pv[i] = 1'b1; pa[i] = rand_fp(); pb[i] = rand_fp(); end
    step();
    chk("t5_lane0_first", 64'(last_ready), 64'd1);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    idle(5);

`ifdef FP_ADD_ARB_FIXED_PRIO_EN
    clear_obs();
    for (int k = 0; k < 20; k++) begin
      if (!pv[0]) begin pv[0] = 1'b1; pa[0] = rand_fp(); pb[0] = rand_fp(); end
      if (!pv[3]) begin pv[3] = 1'b1; pa[3] = rand_fp(); pb[3] = rand_fp(); end
      step();
    end
    chk("t6_lane3_starved", 64'(n_g3), 64'd0);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    idle(5);
`endif

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 2) == 0) begin pv[i] = 1'b1; pa[i] = rand_fp(); pb[i] = rand_fp(); end
      fl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 149) == 0);
      step();
    end
    fl = 1'b0; rs = 1'b0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
